// File: rtl/logpwr_pixel_pkg.sv
// -----------------------------------------------------------------------------
// logpwr_pixel_pkg
// Shared constants and width helpers for the log-power pixel front end.
//   pw_of(iw)  : power width 2*IW+1, wide enough for re^2+im^2 with no overflow
//   ew_of(iw)  : exponent width, clog2 of the power width
//   lw_of(iw,f): log value width, exponent plus F fractional bits
//   sw_of(lw)  : signed width for the offset subtraction, at least LW+2 and
//                wide enough to hold any 32-bit integer offset
//   PIX_*      : pixel width and saturation limits
// -----------------------------------------------------------------------------
package logpwr_pixel_pkg;

    localparam int PIX_W   = 8;
    localparam int PIX_MIN = 0;
    localparam int PIX_MAX = 255;

    function automatic int pw_of(input int iw);
        return 2 * iw + 1;
    endfunction

    function automatic int ew_of(input int iw);
        return $clog2(2 * iw + 1);
    endfunction

    function automatic int lw_of(input int iw, input int f);
        return $clog2(2 * iw + 1) + f;
    endfunction

    function automatic int sw_of(input int lw);
        return (lw + 2 > 34) ? lw + 2 : 34;
    endfunction

endpackage

// File: rtl/logpwr_pixel_log2_approx.sv
// -----------------------------------------------------------------------------
// log2_approx
// Combinational piecewise-linear log2 of an unsigned value.
//   i_pow  : unsigned input value
//   o_exp  : index of the most significant set bit (0 when i_pow is zero)
//   o_frac : the F bits directly below that MSB, zero-padded on the right
//            when fewer than F bits exist below it
//   o_zero : i_pow == 0, the exponent/fraction are meaningless then
// {o_exp, o_frac} is the log2 value with F fractional bits.
// -----------------------------------------------------------------------------
module log2_approx #(
    parameter int PW = 33,
    parameter int F  = 3,
    parameter int EW = $clog2(PW)
) (
    input  logic [PW-1:0] i_pow,
    output logic [EW-1:0] o_exp,
    output logic [F-1:0]  o_frac,
    output logic          o_zero
);

    // Ascending scan: the highest set bit is the last one to write the
    // outputs, so it wins. The fraction window is taken relative to it.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, otherwise a latch is inferred.
        o_exp  = '0;
        o_frac = '0;
        for (int i = 0; i < PW; i++) begin
            if (i_pow[i]) begin
                o_exp  = EW'(i);
                o_frac = '0;
                for (int j = 0; j < F; j++) begin
                    if (i - 1 - j >= 0) begin
                        o_frac[F-1-j] = i_pow[i-1-j];
                    end
                end
            end
        end
    end

    assign o_zero = ~|i_pow;

endmodule

// File: rtl/logpwr_pixel.sv
// -----------------------------------------------------------------------------
// logpwr_pixel
// Converts complex FFT bins into 8-bit log-power pixel indices for the
// false-colour spectrogram map. Four-stage valid/ready pipeline:
//   S1: re^2, im^2         S2: P = re^2 + im^2
//   S3: L = log2(P) (F fractional bits), zero flag
//   S4: clamp(L - OFFSET, 0, 255), forced to 0 when P == 0
// All stages advance on a single global enable ce = !o_valid || i_ready.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_valid/o_ready: input handshake, i_re/i_im signed components, i_last
//   o_valid/i_ready: output handshake, o_pixel, o_last (frame marker)
// -----------------------------------------------------------------------------
module logpwr_pixel
    import logpwr_pixel_pkg::*;
#(
    parameter int IW     = 16,
    parameter int LGFRAC = 3,
    parameter int OFFSET = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IW-1:0]    i_re,
    input  logic [IW-1:0]    i_im,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PIX_W-1:0] o_pixel,
    output logic             o_last
);

    localparam int PW = pw_of(IW);
    localparam int EW = ew_of(IW);
    localparam int LW = lw_of(IW, LGFRAC);
    localparam int SW = sw_of(LW);

    // ---------------- handshake ----------------
    logic ce;
    logic v1_q, v2_q, v3_q, v4_q;

    assign ce      = !v4_q || i_ready;
    assign o_ready = ce;
    assign o_valid = v4_q;

    // ---------------- stage registers ----------------
    logic [2*IW-1:0]    sq_re_q, sq_im_q;
    logic               last1_q;
    logic [PW-1:0]      pow_q;
    logic               last2_q;
    logic [LW-1:0]      lg_q;
    logic               zero3_q;
    logic               last3_q;
    logic [PIX_W-1:0]   pix_q;
    logic               last4_q;

    // ---------------- next-state logic ----------------
    logic signed [2*IW-1:0] sq_re_s, sq_im_s;
    logic [2*IW-1:0]        sq_re_d, sq_im_d;
    logic [PW-1:0]          pow_d;
    logic [EW-1:0]          exp_w;
    logic [LGFRAC-1:0]      frac_w;
    logic                   zero_w;
    logic [LW-1:0]          lg_d;
    logic signed [SW-1:0]   diff_d;
    logic [PIX_W-1:0]       pix_d;

    // Signed products evaluated at 2*IW bits: the largest magnitude,
    // (-2^(IW-1))^2 = 2^(2IW-2), fits without wrapping and is non-negative.
    assign sq_re_s = $signed(i_re) * $signed(i_re);
    assign sq_im_s = $signed(i_im) * $signed(i_im);
    assign sq_re_d = sq_re_s;
    assign sq_im_d = sq_im_s;

    // One extra bit absorbs the carry of the sum.
    assign pow_d = {1'b0, sq_re_q} + {1'b0, sq_im_q};

    log2_approx #(
        .PW (PW),
        .F  (LGFRAC),
        .EW (EW)
    ) u_log2 (
        .i_pow  (pow_q),
        .o_exp  (exp_w),
        .o_frac (frac_w),
        .o_zero (zero_w)
    );

    assign lg_d = {exp_w, frac_w};

    // Zero-extend L into a signed field wide enough that the subtraction
    // of any offset cannot wrap.
    assign diff_d = $signed({{(SW-LW){1'b0}}, lg_q}) - SW'(OFFSET);

    always_comb begin
        pix_d = PIX_W'(PIX_MIN);
        if (zero3_q) begin
            pix_d = PIX_W'(PIX_MIN);
        end else if (diff_d < $signed(SW'(PIX_MIN))) begin
            pix_d = PIX_W'(PIX_MIN);
        end else if (diff_d > $signed(SW'(PIX_MAX))) begin
            pix_d = PIX_W'(PIX_MAX);
        end else begin
            pix_d = diff_d[PIX_W-1:0];
        end
    end

    // ---------------- control and output registers ----------------
    // o_ready equals ce, so an input is accepted exactly when i_valid is
    // sampled with ce high; reset drops any input offered alongside it.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (i_reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            pix_q   <= '0;
            last4_q <= 1'b0;
        end else if (ce) begin
            v1_q    <= i_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            v4_q    <= v3_q;
            pix_q   <= pix_d;
            last4_q <= last3_q;
        end
    end

    // ---------------- datapath registers ----------------
    // NOTE: datapath registers carry no reset; their contents are only
    // observed while the matching valid bit is set, and leaving the reset
    // out keeps the wide registers as plain enable flops.
    always_ff @(posedge i_clk) begin
        if (ce) begin
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            last1_q <= i_last;
            pow_q   <= pow_d;
            last2_q <= last1_q;
            lg_q    <= lg_d;
            zero3_q <= zero_w;
            last3_q <= last2_q;
        end
    end

    assign o_pixel = pix_q;
    assign o_last  = last4_q;

endmodule

// File: tb/tb_logpwr_pixel.sv
// -----------------------------------------------------------------------------
// tb_logpwr_pixel
// Self-checking bench for logpwr_pixel. Three instances share the input
// stream with OFFSET = 0, -16 and 40. Directed vectors carry hand-computed
// pixel values; a random stream is checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_logpwr_pixel;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_re, i_im;
    logic        i_last;
    logic        i_ready;

    logic        o_ready0, o_valid0, o_last0;
    logic [7:0]  o_pixel0;
    logic        o_readyn, o_validn, o_lastn;
    logic [7:0]  o_pixeln;
    logic        o_readyp, o_validp, o_lastp;
    logic [7:0]  o_pixelp;

    always #5 clk = ~clk;

    logpwr_pixel #(.IW(16), .LGFRAC(3), .OFFSET(0)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready0),
        .i_re(i_re), .i_im(i_im), .i_last(i_last), .o_valid(o_valid0),
        .i_ready(i_ready), .o_pixel(o_pixel0), .o_last(o_last0)
    );

    logpwr_pixel #(.IW(16), .LGFRAC(3), .OFFSET(-16)) dut_n (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_readyn),
        .i_re(i_re), .i_im(i_im), .i_last(i_last), .o_valid(o_validn),
        .i_ready(i_ready), .o_pixel(o_pixeln), .o_last(o_lastn)
    );

    logpwr_pixel #(.IW(16), .LGFRAC(3), .OFFSET(40)) dut_p (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_readyp),
        .i_re(i_re), .i_im(i_im), .i_last(i_last), .o_valid(o_validp),
        .i_ready(i_ready), .o_pixel(o_pixelp), .o_last(o_lastp)
    );

    typedef struct {
        logic [7:0] p0;
        logic [7:0] pn;
        logic [7:0] pp;
        logic       last;
        int         acc;
        logic       lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       head;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] cur_p0, cur_pn, cur_pp;
    logic       lat_mode = 1'b0;
    logic       rand_done;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic       prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural reference: exact power, MSB search, fraction window, clamp.
    function automatic logic [7:0] model(input int re, input int im, input int off);
        longint p;
        int     e;
        int     fr;
        longint s;
        p  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        e  = 0;
        fr = 0;
        if (p == 0) return 8'd0;
        for (int i = 0; i < 40; i++) if (p[i]) e = i;
        for (int j = 1; j <= 3; j++) begin
            fr = fr * 2;
            if (e - j >= 0) fr = fr + int'(p[e-j]);
        end
        s = longint'(e * 8 + fr) - longint'(off);
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    // Drive one sample and hold it until accepted (bounded wait).
    task automatic send(input int re, input int im, input logic last,
                        input logic [7:0] e0, input logic [7:0] en, input logic [7:0] ep);
        logic accepted;
        accepted = 1'b0;
        i_valid  = 1'b1;
        i_re     = 16'(re);
        i_im     = 16'(im);
        i_last   = last;
        cur_p0   = e0;
        cur_pn   = en;
        cur_pp   = ep;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_ready0) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check("drain", sb.size(), 32'd0);
        repeat (6) @(posedge clk);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples on the falling edge, scoreboards accepted inputs
    // and transferred outputs, checks hold-stability during stalls.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", o_valid0, 32'd1);
                check("hold_pixel", o_pixel0, prev_pix);
                check("hold_last", o_last0, prev_last);
            end
            if (o_valid0 && !i_ready) check("ready_low", o_ready0, 32'd0);
            prev_stall = o_valid0 && !i_ready;
            prev_pix   = o_pixel0;
            prev_last  = o_last0;
            if (o_valid0 && i_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    head = sb.pop_front();
                    check("pixel_off0", o_pixel0, head.p0);
                    check("last", o_last0, head.last);
                    check("valid_offn16", o_validn, 32'd1);
                    check("pixel_offn16", o_pixeln, head.pn);
                    check("valid_off40", o_validp, 32'd1);
                    check("pixel_off40", o_pixelp, head.pp);
                    if (head.lat) check("latency", cyc - head.acc, 32'd4);
                end
            end
            if (i_valid && o_ready0) begin
                sb.push_back('{cur_p0, cur_pn, cur_pp, i_last, cyc, lat_mode});
            end
        end
    end

    // Watchdog.
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed vectors, hand-computed for OFFSET 0 / -16 / 40.
    int         vre[8] = '{0, 0, 3, 1, 1, -32768, 32767, -1};
    int         vim[8] = '{0, 4, 0, 1, 0, -32768, 32767, 2};
    logic [7:0] ve0[8] = '{0, 32, 25, 8, 0, 248, 247, 18};
    logic [7:0] ven[8] = '{0, 48, 41, 24, 16, 255, 255, 34};
    logic [7:0] vep[8] = '{0, 0, 0, 0, 0, 208, 207, 0};

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_re      = '0;
        i_im      = '0;
        i_last    = 1'b0;
        i_ready   = 1'b1;
        rand_done = 1'b0;
        cur_p0    = '0;
        cur_pn    = '0;
        cur_pp    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_o_valid", o_valid0, 32'd0);
        check("rst_o_pixel", o_pixel0, 32'd0);
        check("rst_o_last", o_last0, 32'd0);
        check("rst_o_ready", o_ready0, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream, last on the 8th, 4-cycle latency.
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(vre[i], vim[i], i == 7, ve0[i], ven[i], vep[i]);
        lat_mode = 1'b0;
        drain();
        #1;

        // Same stream with a 10-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) send(vre[i], vim[i], i == 7, ve0[i], ven[i], vep[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_o_ready", o_ready0, 32'd0);
                check("stall_o_valid", o_valid0, 32'd1);
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();
        #1;

        // Random valid/ready over 10k samples against the model.
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    int re, im;
                    if ($urandom_range(3) == 0) begin
                        repeat ($urandom_range(2, 1)) @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(7))
                        0:       begin re = -32768; im = ($urandom_range(1) == 0) ? -32768 : 32767; end
                        1:       begin re = $urandom_range(3); im = $urandom_range(3); end
                        2:       begin re = int'($urandom_range(255)) - 128; im = 0; end
                        default: begin re = int'($urandom_range(65535)) - 32768;
                                       im = int'($urandom_range(65535)) - 32768; end
                    endcase
                    send(re, im, (n % 64) == 63, model(re, im, 0), model(re, im, -16), model(re, im, 40));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 i_ready = ($urandom_range(3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        #1 i_ready = 1'b1;
        drain();
        #1;

        // Reset with three samples in flight plus one offered during reset.
        send(0, 4, 1'b0, 8'd32, 8'd48, 8'd0);
        send(3, 0, 1'b0, 8'd25, 8'd41, 8'd0);
        send(1, 1, 1'b1, 8'd8, 8'd24, 8'd0);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_re    = 16'd5;
        i_im    = 16'd0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("midrst_o_valid", o_valid0, 32'd0);
        check("midrst_o_ready", o_ready0, 32'd1);
        @(posedge clk);
        #1;
        send(-32768, -32768, 1'b0, 8'd248, 8'd255, 8'd208);
        send(1, 0, 1'b1, 8'd0, 8'd16, 8'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
